// File: rtl/iterative_divider.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU: one trial subtraction and
// one quotient bit per cycle, with single-cycle fast paths for x/0 and signed overflow.
module iterative_divider #(
  parameter int unsigned SIZE = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            signed_op,
  input  logic [SIZE-1:0] dividend,
  input  logic [SIZE-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [SIZE-1:0] quotient,
  output logic [SIZE-1:0] remainder,
  output logic            div_by_zero
);

  localparam int unsigned CW = $clog2(SIZE + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   count;
  logic [SIZE-1:0] q, r, dmag;
  logic            neg_q, neg_r;

  logic            dividend_neg, divisor_neg;
  logic [SIZE-1:0] dividend_mag, divisor_mag;
  logic            zero_div, overflow;
  logic [SIZE-1:0] part;
  logic [SIZE:0]   diff;
  logic [SIZE-1:0] q_step, r_step;

  // Operand conditioning, one restoring step, and next-state selection.
  always_comb begin
    state_next   = state;
    dividend_neg = signed_op & dividend[SIZE-1];
    divisor_neg  = signed_op & divisor[SIZE-1];
    dividend_mag = dividend_neg ? (~dividend + SIZE'(1)) : dividend;
    divisor_mag  = divisor_neg ? (~divisor + SIZE'(1)) : divisor;
    zero_div     = (divisor == '0);
    overflow     = signed_op && (dividend == {1'b1, {(SIZE-1){1'b0}}}) && (&divisor);
    part         = {r[SIZE-2:0], q[SIZE-1]};
    diff         = {1'b0, part} - {1'b0, dmag};
    q_step       = {q[SIZE-2:0], ~diff[SIZE]};
    r_step       = diff[SIZE] ? part : diff[SIZE-1:0];

    case (state)
      IDLE: begin
        if (start) begin
          state_next = (zero_div || overflow) ? DONE : RUN;
        end
      end
      RUN: begin
        if (count == CW'(1)) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, datapath and result registers; results only change entering DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      count       <= '0;
      q           <= '0;
      r           <= '0;
      dmag        <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      done  <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            q     <= dividend_mag;
            r     <= '0;
            dmag  <= divisor_mag;
            count <= CW'(SIZE);
            neg_q <= dividend_neg ^ divisor_neg;
            neg_r <= dividend_neg;
            if (zero_div) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else if (overflow) begin
              quotient    <= dividend;
              remainder   <= '0;
              div_by_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          q     <= q_step;
          r     <= r_step;
          count <= count - CW'(1);
          // Final step: sign-correct the freshly computed magnitudes.
          if (count == CW'(1)) begin
            quotient    <= neg_q ? (~q_step + SIZE'(1)) : q_step;
            remainder   <= neg_r ? (~r_step + SIZE'(1)) : r_step;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_divider.sv
// Directed-vector bench for iterative_divider: results, latency, handshake
// and asynchronous reset behaviour against hand-computed values.
module tb_iterative_divider;

  localparam int unsigned SIZE = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            signed_op;
  logic [SIZE-1:0] dividend;
  logic [SIZE-1:0] divisor;
  logic            busy;
  logic            done;
  logic [SIZE-1:0] quotient;
  logic [SIZE-1:0] remainder;
  logic            div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  iterative_divider #(.SIZE(SIZE)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present an operation in IDLE; returns #1 after the accepting edge.
  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
    signed_op = s;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts cycles from the accepting edge until done; optionally pulses a stray start.
  task automatic wait_done(input int inject, output int cycles, output int busy_cycles);
    cycles      = 1;
    busy_cycles = 0;
    while (1) begin
      if (busy) busy_cycles++;
      if (done || cycles >= 100) break;
      if (cycles == inject) begin
        start     = 1'b1;
        signed_op = 1'b1;
        dividend  = 32'd50;
        divisor   = 32'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                        input logic ez, input int ecyc, input int inject);
    int cyc, bcyc;
    launch(s, a, b);
    wait_done(inject, cyc, bcyc);
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".latency"}, 32'(cyc), 32'(ecyc));
    check({tag, ".busy_cycles"}, 32'(bcyc), 32'(ecyc));
    check({tag, ".quotient"}, quotient, eq);
    check({tag, ".remainder"}, remainder, er);
    check({tag, ".dbz"}, 32'(div_by_zero), 32'(ez));
    @(posedge clk);
    #1;
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
    check({tag, ".busy_after"}, 32'(busy), 32'd0);
    check({tag, ".q_hold"}, quotient, eq);
    check({tag, ".dbz_hold"}, 32'(div_by_zero), 32'(ez));
  endtask

  initial begin
    int done_seen;
    rst       = 1'b1;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.quotient", quotient, 32'd0);
    check("reset.remainder", remainder, 32'd0);
    check("reset.dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Each op starts in the IDLE cycle right after the previous done (back-to-back).
    run_op("u100_7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33, 0);
    run_op("s-7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 33, 0);
    run_op("s7_-2",    1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 33, 0);
    run_op("s-7_-2",   1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0, 33, 0);
    run_op("u8000_1",  1'b0, 32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          1'b0, 33, 0);
    run_op("u_bigdiv", 1'b0, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          32'h7FFF_FFFE,  1'b0, 33, 0);
    run_op("u_dbz",    1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1, 1,  0);
    run_op("s_dbz",    1'b1, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1, 1,  0);
    run_op("s_ovf",    1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 1,  0);
    run_op("u_ovfops", 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, 33, 0);
    run_op("ignore",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33, 10);

    // Asynchronous reset mid-run discards the operation.
    launch(1'b0, 32'd100, 32'd7);
    repeat (14) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.done", 32'(done), 32'd0);
    check("midrst.quotient", quotient, 32'd0);
    check("midrst.remainder", remainder, 32'd0);
    check("midrst.dbz", 32'(div_by_zero), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    check("midrst.no_done", 32'(done_seen), 32'd0);
    run_op("u20_3",    1'b0, 32'd20,         32'd3,          32'd6,          32'd2,          1'b0, 33, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
